// File: rtl/log_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : log_dump_pkg
// Description : Shared types and constants for the log dump sequencer.
//               Build option LOG_DUMP_CSUM_EN adds the checksum state.
// Revision    : 1.0 - initial release
// ============================================================================
package log_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOGGING   = 3'd1,
        ST_FULL_IDLE = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_FETCH     = 3'd4,
        ST_SEND      = 3'd5
`ifdef LOG_DUMP_CSUM_EN
        ,
        ST_CSUM      = 3'd6
`endif
    } state_t;

    localparam logic [1:0] CMD_START_LOG = 2'b01;
    localparam logic [1:0] CMD_DUMP      = 2'b10;
    localparam logic [1:0] CMD_ABORT     = 2'b11;

    localparam int BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/log_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : log_word_serializer
// Description : Loads a logger word and emits it LSB byte first over a
//               registered valid/ready byte channel; flags the last byte.
//               A single-byte load emits only word[7:0].
// Revision    : 1.0 - initial release
// ============================================================================
module log_word_serializer
    import log_dump_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_single,
    input  logic [WORD_WIDTH-1:0] i_word,
    input  logic                  i_ready,
    output logic [7:0]            o_byte,
    output logic                  o_valid,
    output logic                  o_last
);

    localparam logic [1:0] c_last_idx = 2'(BYTES_PER_WORD - 1);

    logic [WORD_WIDTH-1:0] r_shift;
    logic [7:0]            r_byte;
    logic                  r_valid;
    logic [1:0]            r_left;

    // Load takes priority over an in-flight transfer; clear/reset drop the stream.
    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            r_shift <= '0;
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
            r_left  <= 2'd0;
        end else if (i_load) begin
            r_shift <= i_word >> 8;
            r_byte  <= i_word[7:0];
            r_valid <= 1'b1;
            r_left  <= i_single ? 2'd0 : c_last_idx;
        end else if (r_valid && i_ready) begin
            if (r_left == 2'd0) begin
                r_valid <= 1'b0;
            end else begin
                r_byte  <= r_shift[7:0];
                r_shift <= r_shift >> 8;
                r_left  <= r_left - 2'd1;
            end
        end
    end

    assign o_byte  = r_byte;
    assign o_valid = r_valid;
    assign o_last  = r_valid && (r_left == 2'd0);

endmodule
`default_nettype wire

// File: rtl/log_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : log_dump_ctrl
// Description : Capture/dump sequencer for the dual-BRAM sample logger.
//               Starts a capture, waits for full, then sweeps every address
//               and streams each word as four bytes. Build option
//               LOG_DUMP_CSUM_EN appends an XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module log_dump_ctrl
    import log_dump_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int WORD_WIDTH      = 32,
    parameter int RD_LAT          = 1
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_cmd_valid,
    input  logic [1:0]                 i_cmd,
    output logic                       o_cmd_err,
    output logic                       o_run_log,
    output logic                       o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
    input  logic                       i_mem_full,
    input  logic [WORD_WIDTH-1:0]      i_log_word,
    output logic [7:0]                 o_byte,
    output logic                       o_byte_valid,
    input  logic                       i_byte_ready,
    output logic                       o_busy,
    output logic                       o_done
);

    // FETCH lasts RD_LAT+1 cycles: RD_LAT for the read, one to capture it.
    localparam int FETCH_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [FETCH_W-1:0]         c_fetch_last = FETCH_W'(RD_LAT);
    localparam logic [BRAM_ADDR_WIDTH-1:0] c_addr_max   = {BRAM_ADDR_WIDTH{1'b1}};

    state_t                     r_state;
    logic [BRAM_ADDR_WIDTH-1:0] r_addr;
    logic [FETCH_W-1:0]         r_fetch_cnt;
    logic                       r_cmd_err;
    logic                       r_run_log;
    logic                       r_read_log;
    logic                       r_done;
`ifdef LOG_DUMP_CSUM_EN
    logic [7:0]                 r_csum;
    logic [7:0]                 w_csum_next;
`endif

    logic                  w_start;
    logic                  w_dump;
    logic                  w_abort;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_ser_load;
    logic                  w_ser_single;
    logic [WORD_WIDTH-1:0] w_ser_word;

    assign w_start = i_cmd_valid && (i_cmd == CMD_START_LOG);
    assign w_dump  = i_cmd_valid && (i_cmd == CMD_DUMP);
    assign w_abort = i_cmd_valid && (i_cmd == CMD_ABORT);
    assign w_xfer  = o_byte_valid && i_byte_ready;
`ifdef LOG_DUMP_CSUM_EN
    assign w_csum_next = r_csum ^ o_byte;
`endif

    // Serializer load: word capture at the end of FETCH, checksum byte after the last data byte.
    always_comb begin
        w_ser_load   = 1'b0;
        w_ser_single = 1'b0;
        w_ser_word   = i_log_word;
        if (!w_abort) begin
            if (r_state == ST_FETCH && r_fetch_cnt == c_fetch_last) begin
                w_ser_load = 1'b1;
            end
`ifdef LOG_DUMP_CSUM_EN
            else if (r_state == ST_SEND && w_xfer && w_last && r_addr == c_addr_max) begin
                w_ser_load   = 1'b1;
                w_ser_single = 1'b1;
                w_ser_word   = {{(WORD_WIDTH-8){1'b0}}, w_csum_next};
            end
`endif
        end
    end

    // Main sequencer: command handling, address sweep and one-cycle pulses.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_fetch_cnt <= '0;
            r_cmd_err   <= 1'b0;
            r_run_log   <= 1'b0;
            r_read_log  <= 1'b0;
            r_done      <= 1'b0;
`ifdef LOG_DUMP_CSUM_EN
            r_csum      <= 8'h00;
`endif
        end else begin
            r_cmd_err  <= 1'b0;
            r_run_log  <= 1'b0;
            r_read_log <= 1'b0;
            r_done     <= 1'b0;
            if (w_abort) begin
                r_state     <= ST_IDLE;
                r_addr      <= '0;
                r_fetch_cnt <= '0;
`ifdef LOG_DUMP_CSUM_EN
                r_csum      <= 8'h00;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_run_log <= 1'b1;
                            r_state   <= ST_LOGGING;
                        end else if (w_dump) begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                    ST_LOGGING: begin
                        if (w_start || w_dump) r_cmd_err <= 1'b1;
                        if (i_mem_full) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FULL_IDLE;
                        end
                    end
                    ST_FULL_IDLE: begin
                        if (w_dump) begin
                            r_read_log  <= 1'b1;
                            r_addr      <= '0;
                            r_fetch_cnt <= '0;
`ifdef LOG_DUMP_CSUM_EN
                            r_csum      <= 8'h00;
`endif
                            r_state     <= ST_SETTLE;
                        end else if (w_start) begin
                            r_run_log <= 1'b1;
                            r_state   <= ST_LOGGING;
                        end
                    end
                    ST_SETTLE: begin
                        if (w_start || w_dump) r_cmd_err <= 1'b1;
                        r_fetch_cnt <= '0;
                        r_state     <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (w_start || w_dump) r_cmd_err <= 1'b1;
                        if (r_fetch_cnt == c_fetch_last) begin
                            r_state <= ST_SEND;
                        end else begin
                            r_fetch_cnt <= r_fetch_cnt + 1'b1;
                        end
                    end
                    ST_SEND: begin
                        if (w_start || w_dump) r_cmd_err <= 1'b1;
                        if (w_xfer) begin
`ifdef LOG_DUMP_CSUM_EN
                            r_csum <= w_csum_next;
`endif
                            if (w_last) begin
                                if (r_addr == c_addr_max) begin
`ifdef LOG_DUMP_CSUM_EN
                                    r_state <= ST_CSUM;
`else
                                    r_done  <= 1'b1;
                                    r_state <= ST_FULL_IDLE;
`endif
                                end else begin
                                    r_addr      <= r_addr + 1'b1;
                                    r_fetch_cnt <= '0;
                                    r_state     <= ST_FETCH;
                                end
                            end
                        end
                    end
`ifdef LOG_DUMP_CSUM_EN
                    ST_CSUM: begin
                        if (w_start || w_dump) r_cmd_err <= 1'b1;
                        if (w_xfer) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FULL_IDLE;
                        end
                    end
`endif
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    log_word_serializer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_serializer (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_clear  (w_abort),
        .i_load   (w_ser_load),
        .i_single (w_ser_single),
        .i_word   (w_ser_word),
        .i_ready  (i_byte_ready),
        .o_byte   (o_byte),
        .o_valid  (o_byte_valid),
        .o_last   (w_last)
    );

    assign o_cmd_err  = r_cmd_err;
    assign o_run_log  = r_run_log;
    assign o_read_log = r_read_log;
    assign o_addr_log = r_addr;
    assign o_done     = r_done;
    assign o_busy     = (r_state != ST_IDLE) && (r_state != ST_FULL_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_log_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_log_dump_ctrl
// Description : Scoreboard bench for log_dump_ctrl with a logger model.
//               Honours LOG_DUMP_CSUM_EN when defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_log_dump_ctrl;
    import log_dump_pkg::*;

    localparam int AW     = 3;
    localparam int NW     = 1 << AW;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic [1:0]    i_cmd = 2'b00;
    logic          i_mem_full = 1'b0;
    logic [31:0]   i_log_word = '0;
    logic          i_byte_ready = 1'b1;
    logic          o_cmd_err, o_run_log, o_read_log, o_byte_valid, o_busy, o_done;
    logic [AW-1:0] o_addr_log;
    logic [7:0]    o_byte;

    log_dump_ctrl #(
        .BRAM_ADDR_WIDTH (AW),
        .WORD_WIDTH      (32),
        .RD_LAT          (RD_LAT)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_cmd_valid  (i_cmd_valid),
        .i_cmd        (i_cmd),
        .o_cmd_err    (o_cmd_err),
        .o_run_log    (o_run_log),
        .o_read_log   (o_read_log),
        .o_addr_log   (o_addr_log),
        .i_mem_full   (i_mem_full),
        .i_log_word   (i_log_word),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    // Logger model: registered read with one cycle of latency.
    logic [31:0] mem [NW];
    always @(posedge clk) i_log_word <= mem[o_addr_log];

    typedef struct {
        logic [7:0]    b;
        logic [AW-1:0] a;
        bit            cs;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] got[$];
    logic [7:0] first_stream[$];
    int         xcyc[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b0;
    bit         prev_wait = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: every word LSB byte first, address ascending, optional XOR trailer.
    task automatic build_expected();
`ifdef LOG_DUMP_CSUM_EN
        logic [7:0] cs;
        exp_t       t;
        cs = 8'h00;
`endif
        exp_q.delete();
        got.delete();
        xcyc.delete();
        for (int a = 0; a < NW; a++) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                exp_t e;
                e.b  = mem[a][8*b +: 8];
                e.a  = a[AW-1:0];
                e.cs = 1'b0;
                exp_q.push_back(e);
`ifdef LOG_DUMP_CSUM_EN
                cs = cs ^ e.b;
`endif
            end
        end
`ifdef LOG_DUMP_CSUM_EN
        t.b  = cs;
        t.a  = '1;
        t.cs = 1'b1;
        exp_q.push_back(t);
`endif
    endtask

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait) begin
                check("valid held while stalled", {31'b0, o_byte_valid}, 32'd1);
                check("byte stable while stalled", {24'b0, o_byte}, {24'b0, prev_byte});
            end
            if (o_byte_valid && i_byte_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra byte valid", {31'b0, o_byte_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(e.cs ? "checksum byte" : "data byte", {24'b0, o_byte}, {24'b0, e.b});
                    if (!e.cs) check("address at byte", {29'b0, o_addr_log}, {29'b0, e.a});
                end
                got.push_back(o_byte);
                xcyc.push_back(cyc);
            end
            prev_wait = o_byte_valid && !i_byte_ready;
            prev_byte = o_byte;
        end
    end

    task automatic do_cmd(input logic [1:0] c);
        @(posedge clk); #1;
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        i_cmd       = 2'b00;
    endtask

    task automatic run_dump(input bit rand_ready, input bit drop_full);
        bit seen;
        build_expected();
        mon_en = 1'b1;
        do_cmd(CMD_DUMP);
        check("read_log pulse", {31'b0, o_read_log}, 32'd1);
        check("busy during dump", {31'b0, o_busy}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk); #1;
            if (o_done) seen = 1'b1;
            else i_byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drop_full && i == 30) i_mem_full = 1'b0;
        end
        i_byte_ready = 1'b1;
        check("dump done seen", {31'b0, seen}, 32'd1);
        check("scoreboard drained", exp_q.size(), 32'd0);
        check("idle after dump", {31'b0, o_busy}, 32'd0);
        @(posedge clk); #1;
        check("done is one pulse", {31'b0, o_done}, 32'd0);
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 2000 && got.size() < n; i++) begin
            @(posedge clk); #1;
        end
        check("reached byte count", {31'b0, got.size() >= n}, 32'd1);
    endtask

    task automatic capture();
        i_mem_full = 1'b0;
        do_cmd(CMD_START_LOG);
        check("run_log pulse", {31'b0, o_run_log}, 32'd1);
        check("busy while logging", {31'b0, o_busy}, 32'd1);
        repeat (19) @(posedge clk);
        #1 i_mem_full = 1'b1;
        @(posedge clk); #1;
        check("capture done", {31'b0, o_done}, 32'd1);
        check("not busy when full", {31'b0, o_busy}, 32'd0);
    endtask

    initial begin
        int bad;
        for (int a = 0; a < NW; a++) mem[a] = 32'hA0B0C0D0 + a;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check("reset byte_valid", {31'b0, o_byte_valid}, 32'd0);
        check("reset busy", {31'b0, o_busy}, 32'd0);
        check("reset addr", {29'b0, o_addr_log}, 32'd0);
        check("reset pulses", {28'b0, o_done, o_run_log, o_read_log, o_cmd_err}, 32'd0);

        // DUMP is illegal in IDLE.
        do_cmd(CMD_DUMP);
        check("dump in idle err", {31'b0, o_cmd_err}, 32'd1);
        check("dump in idle no read", {31'b0, o_read_log}, 32'd0);
        check("idle unchanged", {31'b0, o_busy}, 32'd0);

        // Capture, with an illegal START_LOG while logging.
        i_mem_full = 1'b0;
        do_cmd(CMD_START_LOG);
        check("run_log pulse", {31'b0, o_run_log}, 32'd1);
        check("busy while logging", {31'b0, o_busy}, 32'd1);
        @(posedge clk); #1;
        check("run_log one cycle", {31'b0, o_run_log}, 32'd0);
        do_cmd(CMD_START_LOG);
        check("start in logging err", {31'b0, o_cmd_err}, 32'd1);
        check("start in logging no run", {31'b0, o_run_log}, 32'd0);
        check("still logging", {31'b0, o_busy}, 32'd1);
        repeat (17) @(posedge clk);
        #1 i_mem_full = 1'b1;
        @(posedge clk); #1;
        check("capture done", {31'b0, o_done}, 32'd1);
        check("not busy when full", {31'b0, o_busy}, 32'd0);
        @(posedge clk); #1;
        check("capture done one cycle", {31'b0, o_done}, 32'd0);

        // Ready held high: byte order and inter-word spacing.
        i_byte_ready = 1'b1;
        run_dump(1'b0, 1'b0);
        bad = 0;
        for (int i = 1; i < NW * BYTES_PER_WORD && i < xcyc.size(); i++) begin
            if (xcyc[i] - xcyc[i-1] != ((i % BYTES_PER_WORD) == 0 ? 2 + RD_LAT : 1)) bad++;
        end
        check("byte spacing", bad, 32'd0);
        first_stream = got;

        // Re-dump with random backpressure and a full-flag drop: identical stream.
        run_dump(1'b1, 1'b1);
        check("redump length", got.size(), first_stream.size());
        bad = 0;
        for (int i = 0; i < got.size() && i < first_stream.size(); i++)
            if (got[i] !== first_stream[i]) bad++;
        check("redump identical", bad, 32'd0);

        // Random memory contents, random backpressure.
        for (int a = 0; a < NW; a++) mem[a] = $urandom;
        run_dump(1'b1, 1'b0);

        // Checksum-oriented patterns (plain data streams when the option is off).
        for (int a = 0; a < NW; a++) mem[a] = 32'h01020304;
        run_dump(1'b1, 1'b0);
        for (int a = 0; a < NW; a++) mem[a] = 32'h00000001;
        run_dump(1'b0, 1'b0);
        for (int a = 0; a < NW; a++) mem[a] = (a == 0) ? 32'h1 : 32'h0;
        run_dump(1'b1, 1'b0);

        // ABORT mid-SEND after byte 13.
        for (int a = 0; a < NW; a++) mem[a] = 32'hA0B0C0D0 + a;
        build_expected();
        mon_en = 1'b1;
        do_cmd(CMD_DUMP);
        wait_bytes(13);
        mon_en       = 1'b0;
        i_byte_ready = 1'b0;
        i_cmd_valid  = 1'b1;
        i_cmd        = CMD_ABORT;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        i_cmd       = 2'b00;
        check("abort drops valid", {31'b0, o_byte_valid}, 32'd0);
        check("abort to idle", {31'b0, o_busy}, 32'd0);
        check("abort no pulses", {28'b0, o_done, o_run_log, o_read_log, o_cmd_err}, 32'd0);
        check("abort clears addr", {29'b0, o_addr_log}, 32'd0);
        exp_q.delete();
        i_byte_ready = 1'b1;
        do_cmd(CMD_DUMP);
        check("dump after abort err", {31'b0, o_cmd_err}, 32'd1);

        // Fresh capture, then reset mid-dump.
        capture();
        for (int a = 0; a < NW; a++) mem[a] = $urandom;
        build_expected();
        mon_en = 1'b1;
        do_cmd(CMD_DUMP);
        wait_bytes(10);
        mon_en = 1'b0;
        i_rst  = 1'b1;
        @(posedge clk); #1;
        check("rst stream valid", {31'b0, o_byte_valid}, 32'd0);
        check("rst byte", {24'b0, o_byte}, 32'd0);
        check("rst addr", {29'b0, o_addr_log}, 32'd0);
        check("rst busy and pulses", {27'b0, o_busy, o_done, o_run_log, o_read_log, o_cmd_err}, 32'd0);
        i_rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("no resume after reset", {30'b0, o_byte_valid, o_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
